// File: rtl/fsm_flow_ctrl_if.sv
// Flow-control controller bus: configuration, FIFO status in; thresholds and state out.
// Latency: none (wiring only); every signal is owned by one side through its modport.
// Backpressure: none; level signals sampled by the controller on every clock edge.
interface fsm_flow_ctrl_if #(
    parameter int NUM_FIFOS = 5,
    parameter int TW        = 5
);
    logic                    init;
    logic [NUM_FIFOS*TW-1:0] low_th_in;
    logic [NUM_FIFOS*TW-1:0] high_th_in;
    logic [NUM_FIFOS-1:0]    empties;
    logic [NUM_FIFOS-1:0]    errors;
    logic [NUM_FIFOS*TW-1:0] low_th_out;
    logic [NUM_FIFOS*TW-1:0] high_th_out;
    logic [2:0]              state;
    logic                    idle_out;
    logic                    active_out;
    logic                    error_out;
    logic                    cfg_bad;
    logic [NUM_FIFOS-1:0]    error_fifo;

    // Environment side: drives configuration and FIFO status, observes the controller.
    modport master (
        output init, low_th_in, high_th_in, empties, errors,
        input  low_th_out, high_th_out, state, idle_out, active_out,
               error_out, cfg_bad, error_fifo
    );

    // Controller side.
    modport slave (
        input  init, low_th_in, high_th_in, empties, errors,
        output low_th_out, high_th_out, state, idle_out, active_out,
               error_out, cfg_bad, error_fifo
    );
endinterface

// File: rtl/fsm_flow_ctrl.sv
// Flow-control FSM: programs/validates per-FIFO thresholds, tracks idle/active, latches FIFO errors.
// Latency: one edge from any sampled input to every (registered, Moore) output.
// Backpressure: none; holds in INIT while init is requested or the thresholds are inconsistent.
module fsm_flow_ctrl #(
    parameter int NUM_FIFOS = 5,
    parameter int TW        = 5
) (
    input  logic          clk,
    input  logic          reset,
    fsm_flow_ctrl_if.slave bus
);
    localparam logic [2:0] S_RESET  = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_IDLE   = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_ERROR  = 3'd4;

    logic [2:0]              r_state;
    logic                    r_idle;
    logic                    r_active;
    logic                    r_error;
    logic                    r_cfg_bad;
    logic [NUM_FIFOS*TW-1:0] r_low_th;
    logic [NUM_FIFOS*TW-1:0] r_high_th;
    logic [NUM_FIFOS-1:0]    r_error_fifo;

    logic [2:0]              w_next;
    logic                    w_cfg_bad;
    logic                    w_any_err;
    logic                    w_all_empty;

    assign w_any_err   = |bus.errors;
    assign w_all_empty = &bus.empties;

    // Configuration is inconsistent if any FIFO has its low threshold above its high one.
    always_comb begin
        w_cfg_bad = 1'b0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            if (bus.low_th_in[i*TW +: TW] > bus.high_th_in[i*TW +: TW]) begin
                w_cfg_bad = 1'b1;
            end
        end
    end

    // Next state; errors beat init, init beats empty-flag changes, illegal codes recover via RESET.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RESET: w_next = S_INIT;
            S_INIT: begin
                if (!bus.init && !w_cfg_bad) begin
                    w_next = S_IDLE;
                end
            end
            S_IDLE: begin
                if (w_any_err) begin
                    w_next = S_ERROR;
                end else if (bus.init) begin
                    w_next = S_INIT;
                end else if (!w_all_empty) begin
                    w_next = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (w_any_err) begin
                    w_next = S_ERROR;
                end else if (bus.init) begin
                    w_next = S_INIT;
                end else if (w_all_empty) begin
                    w_next = S_IDLE;
                end
            end
            S_ERROR: w_next = S_ERROR;
            default: w_next = S_RESET;
        endcase
    end

    // State register plus decoded status flags, registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_RESET;
            r_idle   <= 1'b0;
            r_active <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_idle   <= (w_next == S_IDLE);
            r_active <= (w_next == S_ACTIVE);
            r_error  <= (w_next == S_ERROR);
        end
    end

    // Thresholds follow the inputs on every INIT edge and are frozen everywhere else.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_low_th  <= '0;
            r_high_th <= '0;
        end else if (r_state == S_INIT) begin
            r_low_th  <= bus.low_th_in;
            r_high_th <= bus.high_th_in;
        end
    end

    // Config-error flag only lives in INIT; INIT is never left while it would be set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cfg_bad <= 1'b0;
        end else begin
            r_cfg_bad <= (r_state == S_INIT) && w_cfg_bad;
        end
    end

    // Sticky per-FIFO error record: loaded on ERROR entry, accumulated while in ERROR.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_error_fifo <= '0;
        end else if (w_next == S_ERROR) begin
            if (r_state == S_ERROR) begin
                r_error_fifo <= r_error_fifo | bus.errors;
            end else begin
                r_error_fifo <= bus.errors;
            end
        end else begin
            r_error_fifo <= '0;
        end
    end

    assign bus.state       = r_state;
    assign bus.idle_out    = r_idle;
    assign bus.active_out  = r_active;
    assign bus.error_out   = r_error;
    assign bus.cfg_bad     = r_cfg_bad;
    assign bus.low_th_out  = r_low_th;
    assign bus.high_th_out = r_high_th;
    assign bus.error_fifo  = r_error_fifo;
endmodule

// File: tb/tb_fsm_flow_ctrl.sv
// Bench for fsm_flow_ctrl: a 5x5 instance tracked cycle-by-cycle against a behavioural model,
// plus an 8x7 instance checked at full-scale thresholds.
// Directed vectors applied 2 time units after each rising edge.
module tb_fsm_flow_ctrl;
    localparam int N  = 5;
    localparam int W  = 5;
    localparam int N2 = 8;
    localparam int W2 = 7;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fsm_flow_ctrl_if #(.NUM_FIFOS(N),  .TW(W))  ia ();
    fsm_flow_ctrl_if #(.NUM_FIFOS(N2), .TW(W2)) ib ();

    fsm_flow_ctrl #(.NUM_FIFOS(N),  .TW(W))  dut_a (.clk(clk), .reset(reset), .bus(ia.slave));
    fsm_flow_ctrl #(.NUM_FIFOS(N2), .TW(W2)) dut_b (.clk(clk), .reset(reset), .bus(ib.slave));

    int n_total = 0;
    int n_bad   = 0;
    bit cmp_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // ---------------- behavioural model of the 5x5 instance ----------------
    // States as plain integers: 0 reset, 1 programming, 2 idle, 3 active, 4 error.
    int          m_state;
    int          m_lo [N];
    int          m_hi [N];
    bit          m_bad;
    bit [N-1:0]  m_ef;

    always @(posedge clk or negedge reset) begin : model
        int  nxt;
        bit  bad;
        int  lo_v, hi_v;
        if (!reset) begin
            m_state = 0;
            m_bad   = 0;
            m_ef    = '0;
            for (int i = 0; i < N; i++) begin
                m_lo[i] = 0;
                m_hi[i] = 0;
            end
        end else begin
            bad = 0;
            for (int i = 0; i < N; i++) begin
                lo_v = int'(ia.low_th_in[i*W +: W]);
                hi_v = int'(ia.high_th_in[i*W +: W]);
                if (lo_v > hi_v) bad = 1;
            end
            nxt = m_state;
            if (m_state == 0) begin
                nxt = 1;
            end else if (m_state == 1) begin
                for (int i = 0; i < N; i++) begin
                    m_lo[i] = int'(ia.low_th_in[i*W +: W]);
                    m_hi[i] = int'(ia.high_th_in[i*W +: W]);
                end
                if (!ia.init && !bad) nxt = 2;
            end else if (m_state == 2 || m_state == 3) begin
                if (ia.errors != 0)                            nxt = 4;
                else if (ia.init)                              nxt = 1;
                else if (m_state == 2 && ia.empties != {N{1'b1}}) nxt = 3;
                else if (m_state == 3 && ia.empties == {N{1'b1}}) nxt = 2;
            end
            m_bad = (m_state == 1) && bad;
            if (nxt == 4) m_ef = (m_state == 4) ? (m_ef | ia.errors) : ia.errors;
            else          m_ef = '0;
            m_state = nxt;
        end
    end

    // Compare the 5x5 instance against the model on every falling edge.
    always @(negedge clk) begin : compare
        logic [N*W-1:0] exp_lo, exp_hi;
        if (cmp_en) begin
            for (int i = 0; i < N; i++) begin
                exp_lo[i*W +: W] = m_lo[i][W-1:0];
                exp_hi[i*W +: W] = m_hi[i][W-1:0];
            end
            check("m_state",  64'(ia.state),       64'(m_state));
            check("m_idle",   64'(ia.idle_out),    64'(m_state == 2));
            check("m_active", 64'(ia.active_out),  64'(m_state == 3));
            check("m_error",  64'(ia.error_out),   64'(m_state == 4));
            check("m_cfgbad", 64'(ia.cfg_bad),     64'(m_bad));
            check("m_ef",     64'(ia.error_fifo),  64'(m_ef));
            check("m_lo",     64'(ia.low_th_out),  64'(exp_lo));
            check("m_hi",     64'(ia.high_th_out), 64'(exp_hi));
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    initial begin
        logic [N*W-1:0]   v_lo, v_hi;
        logic [N2*W2-1:0] v_max2;

        reset         = 1'b0;
        ia.init       = 1'b0;
        ia.low_th_in  = '0;
        ia.high_th_in = '0;
        ia.empties    = '1;
        ia.errors     = '0;
        ib.init       = 1'b0;
        ib.low_th_in  = '0;
        ib.high_th_in = '0;
        ib.empties    = '1;
        ib.errors     = '0;

        repeat (2) @(posedge clk);
        #2;
        check("rst_state", 64'(ia.state), 64'd0);
        check("rst_flags", 64'({ia.idle_out, ia.active_out, ia.error_out, ia.cfg_bad}), 64'd0);
        check("rst_th",    64'({ia.low_th_out, ia.high_th_out}), 64'd0);
        check("rst_ef",    64'(ia.error_fifo), 64'd0);
        cmp_en = 1'b1;

        // Programming: low=3, high=6 everywhere; 8x7 instance at full scale.
        v_lo   = {N{5'd3}};
        v_hi   = {N{5'd6}};
        v_max2 = {N2{7'h7F}};
        reset         = 1'b1;
        ia.init       = 1'b1;
        ia.low_th_in  = v_lo;
        ia.high_th_in = v_hi;
        ib.init       = 1'b1;
        ib.low_th_in  = v_max2;
        ib.high_th_in = v_max2;
        step();
        check("s1_state_init",  64'(ia.state), 64'd1);
        check("s1b_state_init", 64'(ib.state), 64'd1);
        step();
        check("s1_state_hold",  64'(ia.state), 64'd1);
        check("s1_lo",          64'(ia.low_th_out),  64'(v_lo));
        check("s1_hi",          64'(ia.high_th_out), 64'(v_hi));
        check("s1b_lo",         64'(ib.low_th_out),  64'(v_max2));
        ia.init = 1'b0;
        ib.init = 1'b0;
        step();
        check("s1_state_idle",  64'(ia.state),    64'd2);
        check("s1_idle_out",    64'(ia.idle_out), 64'd1);
        check("s1b_state_idle", 64'(ib.state),    64'd2);
        check("s1b_cfgbad",     64'(ib.cfg_bad),  64'd0);
        check("s1b_hi",         64'(ib.high_th_out), 64'(v_max2));

        // Idle <-> active on the empty flags.
        ia.empties = 5'b11110;
        step();
        check("s2_active",     64'(ia.state),      64'd3);
        check("s2_active_out", 64'(ia.active_out), 64'd1);
        ia.empties = 5'b11111;
        step();
        check("s2_back_idle",  64'(ia.state),      64'd2);
        ia.empties = 5'b11110;
        step();

        // Error and init together in ACTIVE: error wins, then accumulates.
        ia.errors = 5'b00100;
        ia.init   = 1'b1;
        step();
        check("s3_state_err", 64'(ia.state),      64'd4);
        check("s3_ef1",       64'(ia.error_fifo), 64'(5'b00100));
        check("s3_err_out",   64'(ia.error_out),  64'd1);
        ia.errors = 5'b00001;
        ia.init   = 1'b0;
        step();
        check("s3_ef2",       64'(ia.error_fifo), 64'(5'b00101));
        ia.errors  = '0;
        ia.empties = 5'b11111;
        step();
        check("s3_absorb",    64'(ia.state),      64'd4);
        check("s3_ef_sticky", 64'(ia.error_fifo), 64'(5'b00101));

        // Asynchronous reset out of ERROR, between edges.
        reset = 1'b0;
        #1;
        check("s5e_state",  64'(ia.state),     64'd0);
        check("s5e_err",    64'(ia.error_out), 64'd0);
        check("s5e_ef",     64'(ia.error_fifo), 64'd0);
        check("s5e_th",     64'(ia.low_th_out), 64'd0);
        step();

        // Inconsistent config on FIFO 2 (low 0xA > high 0x7); errors ignored in INIT.
        v_lo = {5'd1, 5'd1, 5'hA, 5'd1, 5'd1};
        v_hi = {5'd2, 5'd2, 5'h7, 5'd2, 5'd2};
        ia.low_th_in  = v_lo;
        ia.high_th_in = v_hi;
        reset = 1'b1;
        step();
        check("s4_init",      64'(ia.state),   64'd1);
        check("s4_cfg0",      64'(ia.cfg_bad), 64'd0);
        ia.errors = 5'b01000;
        step();
        check("s4_stay",      64'(ia.state),   64'd1);
        check("s4_cfgbad",    64'(ia.cfg_bad), 64'd1);
        ia.errors = '0;
        v_hi = {5'd2, 5'd2, 5'hA, 5'd2, 5'd2};
        ia.high_th_in = v_hi;
        step();
        check("s4_idle",      64'(ia.state),   64'd2);
        check("s4_cfg_clr",   64'(ia.cfg_bad), 64'd0);
        check("s4_lo",        64'(ia.low_th_out),  64'(v_lo));
        check("s4_hi",        64'(ia.high_th_out), 64'(v_hi));

        // Init beats empty-flag change from IDLE.
        ia.init    = 1'b1;
        ia.empties = 5'b11110;
        step();
        check("s6_init_wins", 64'(ia.state), 64'd1);

        // Full-scale thresholds with low == high are valid.
        v_lo = {N{5'h1F}};
        ia.low_th_in  = v_lo;
        ia.high_th_in = v_lo;
        ia.init       = 1'b0;
        ia.empties    = 5'b11111;
        step();
        check("s7_idle",  64'(ia.state),       64'd2);
        check("s7_hi",    64'(ia.high_th_out), 64'(v_lo));
        check("s7_lo",    64'(ia.low_th_out),  64'(v_lo));

        // Asynchronous reset in ACTIVE, then release.
        ia.empties = 5'b11110;
        step();
        check("s8_active", 64'(ia.state), 64'd3);
        reset = 1'b0;
        #1;
        check("s8_state",  64'(ia.state),      64'd0);
        check("s8_act",    64'(ia.active_out), 64'd0);
        check("s8_th",     64'(ia.high_th_out), 64'd0);
        step();
        reset = 1'b1;
        step();
        check("s8_reinit", 64'(ia.state), 64'd1);
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/fsm_flow_ctrl.md
# fsm_flow_ctrl

Parametrised flow-control state machine for the switch datapath. It sequences the design through reset, threshold programming, idle, active and error states. In the programming state it captures per-FIFO low/high almost-empty/almost-full thresholds and validates them, then publishes them to the FIFOs. It generalises the fixed five-FIFO controller (main, VC0, VC1, D0, D1) to `NUM_FIFOS` FIFOs of any threshold width. It adds configuration checking, priority-ordered transitions and sticky per-FIFO error capture.

## Interface
- `NUM_FIFOS`, 5, number of FIFOs supervised (≥1); FIFO 0 is the main FIFO.
- `TW`, 5, width of each threshold field in bits.
- `clk`  input  1  single clock; all state changes on rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `init`  input  1  request to enter or remain in threshold programming.
- `low_th_in`  input  NUM_FIFOS*TW  packed low thresholds; FIFO i at bits [i*TW +: TW].
- `high_th_in`  input  NUM_FIFOS*TW  packed high thresholds, same packing.
- `empties`  input  NUM_FIFOS  per-FIFO empty flags (1 = empty).
- `errors`  input  NUM_FIFOS  per-FIFO error flags (1 = error).
- `low_th_out`  output  NUM_FIFOS*TW  registered low thresholds driven to the FIFOs.
- `high_th_out`  output  NUM_FIFOS*TW  registered high thresholds.
- `state`  output  3  current state code.
- `idle_out`  output  1  high in IDLE.
- `active_out`  output  1  high in ACTIVE.
- `error_out`  output  1  high in ERROR.
- `cfg_bad`  output  1  high while in INIT with a captured configuration where some low > high.
- `error_fifo`  output  NUM_FIFOS  sticky record of which FIFOs signalled errors.

## Operation
- State codes: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4; codes 5–7 are illegal and return to RESET on the next edge.
- RESET: unconditionally moves to INIT on the first edge with `reset`=1.
- INIT:
  - Every cycle, registers `low_th_in`/`high_th_in` into `low_th_out`/`high_th_out`.
  - Registers `cfg_bad` as the OR over i of (low_i > high_i), unsigned, using the inputs sampled on the same edge.
  - Transition condition: `init`=0 and the `cfg_bad` computed from the inputs sampled on the same edge is 0 → IDLE.
  - Otherwise the block stays in INIT.
  - `errors` is ignored in INIT.
- IDLE and ACTIVE transitions, in priority order:
  1. any `errors` bit set → ERROR;
  2. `init`=1 → INIT;
  3. from IDLE, `empties` not all ones → ACTIVE; from ACTIVE, `empties` all ones → IDLE;
  4. otherwise hold.
- ERROR:
  - Absorbing; only `reset` exits.
  - `error_fifo` loads `errors` on the entry edge and ORs in `errors` every subsequent cycle.
- Thresholds:
  - Held unchanged outside INIT.
  - Re-entering INIT from IDLE/ACTIVE overwrites them from the first INIT edge onward.
- `cfg_bad` is cleared on any edge that leaves INIT, and is 0 in all other states.
- `error_fifo` is 0 in every state except ERROR.

## Timing
- Reset values (asynchronous, while `reset`=0):
  - `state`=RESET;
  - all threshold outputs 0;
  - `idle_out`, `active_out`, `error_out`, `cfg_bad`=0;
  - `error_fifo`=0.
- All outputs are registered and Moore-style; none depends combinationally on inputs.
- An input sampled at edge k affects outputs immediately after edge k (one-edge latency).
- Threshold latency: a value present at an INIT-state edge appears on `*_th_out` right after that edge.
- Reset asserted mid-operation, including in ERROR, clears everything immediately without waiting for a clock.
- Deassertion is taken synchronously on the next edge as the RESET→INIT step.
- Simultaneous `errors` and `init` in IDLE/ACTIVE: ERROR wins.
- Simultaneous `init` and empties change: INIT wins.
- `low`=`high` for a FIFO is valid.
- Thresholds at maximum (all ones) are valid and must not wrap.

## Test plan
- Reset, then `init`=1 for 2 cycles with low=3, high=6 on all FIFOs, then `init`=0 with `empties` all ones:
  - state goes 0→1→1→2;
  - `low_th_out` fields = 3 and `high_th_out` fields = 6;
  - `idle_out`=1.
- From IDLE, set `empties`=5'b11110 → ACTIVE with `active_out`=1 next edge; restore to 5'b11111 → IDLE next edge.
- In ACTIVE, pulse `errors`=5'b00100 and `init`=1 together for one cycle, then `errors`=5'b00001:
  - ERROR entered;
  - `error_fifo`=5'b00100, then 5'b00101;
  - `error_out` stays 1 until reset.
- INIT with FIFO 2 low=0xA, high=0x7 and `init`=0:
  - stays in INIT with `cfg_bad`=1;
  - correcting high to 0xA → IDLE on that edge, `cfg_bad`=0.
- Assert `reset`=0 between clock edges while in ACTIVE:
  - all outputs 0 and `state`=0 before the next edge;
  - release → INIT one edge later.
- Re-parameterise `NUM_FIFOS`=8, `TW`=7 and repeat scenario 1 with low=0x7F, high=0x7F: thresholds captured exactly, no `cfg_bad`.
